// File: rtl/mips_seq_ctrl.sv
// Multi-cycle phase sequencer for the 8-bit MIPS datapath.
// Define MIPS_SEQ_DEBOUNCE_EN to filter the Step pushbutton.
module mips_seq_ctrl #(
  parameter int TICK_DIV        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       Clk_O,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Step,
  input  logic       Halt_Req,
  input  logic [1:0] Opcode,
  output logic       IR_Load,
  output logic       Reg_Read_En,
  output logic       Mem_Read_En,
  output logic       Mem_Write_En,
  output logic       Reg_Write_En,
  output logic       PC_En,
  output logic       PC_Sel,
  output logic [2:0] Phase,
  output logic       Busy,
  output logic       Halted,
  output logic [7:0] Retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_LW = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;
  localparam logic [1:0] OP_BR = 2'b11;

  localparam int TW = $clog2(TICK_DIV);

  if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_chk
    $error("mips_seq_ctrl: TICK_DIV/DEBOUNCE_CYCLES out of range");
  end

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     op_q;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic           step_s1;
  logic           step_s2;
  logic           step_lvl;
  logic           step_lvl_q;
  logic           step_pulse;

  // Free-running launch pacer; never gated by the FSM.
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
    end else begin
      step_s1 <= Step;
      step_s2 <= step_s1;
    end
  end

`ifdef MIPS_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt;
  logic          db_lvl;

  // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (step_s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= step_s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign step_lvl = db_lvl;
`else
  assign step_lvl = step_s2;
`endif

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      step_lvl_q <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_lvl_q <= step_lvl;
      step_pulse <= step_lvl & ~step_lvl_q;
    end
  end

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_R;
      Retired <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= Opcode;
      if (state_q == S_PCUPD)
        Retired <= Retired + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Halt_Req)
          state_d = S_HALT;
        else if (Run && tick)
          state_d = S_FETCH;
        else if (!Run && step_pulse)
          state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (op_q)
          OP_R:    state_d = S_WB;
          OP_LW:   state_d = S_MEM;
          OP_SW:   state_d = S_MEM;
          default: state_d = S_PCUPD;
        endcase
      end
      S_MEM:   state_d = (op_q == OP_LW) ? S_WB : S_PCUPD;
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: state_d = S_IDLE;
      S_HALT:  state_d = Halt_Req ? S_HALT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IR_Load      = 1'b0;
    Reg_Read_En  = 1'b0;
    Mem_Read_En  = 1'b0;
    Mem_Write_En = 1'b0;
    Reg_Write_En = 1'b0;
    PC_En        = 1'b0;
    unique case (state_q)
      S_FETCH:  IR_Load     = 1'b1;
      S_DECODE: Reg_Read_En = 1'b1;
      S_MEM: begin
        Mem_Read_En  = (op_q == OP_LW);
        Mem_Write_En = (op_q == OP_SW);
      end
      S_WB:     Reg_Write_En = 1'b1;
      S_PCUPD:  PC_En        = 1'b1;
      default:  ;
    endcase
    PC_Sel = (op_q == OP_BR);
    Phase  = state_q;
    Busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    Halted = (state_q == S_HALT);
  end

endmodule
